// File: rtl/lrot_pkg.sv
// Shared constants and FSM encoding for the sequential 16-bit rotate unit.
//   WIDTH : operand width (only 16 supported)
//   SHW   : rotate-amount width, log2(WIDTH)
//   state_t : S_IDLE / S_ROT / S_HOLD
package lrot_pkg;

  localparam int unsigned WIDTH = 16;
  localparam int unsigned SHW   = 4;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ROT  = 2'd1,
    S_HOLD = 2'd2
  } state_t;

endpackage : lrot_pkg

// File: rtl/lrot16_step.sv
// Combinational single-position rotate.
// Optional feature macro: LROT_DIR_EN (adds dir input; dir=1 rotates right).
// Ports:
//   d   : operand in
//   dir : rotate direction, 1 = right (LROT_DIR_EN only)
//   q   : operand rotated by one bit position
module lrot16_step
  import lrot_pkg::*;
(
  input  logic [WIDTH-1:0] d,
`ifdef LROT_DIR_EN
  input  logic             dir,
`endif
  output logic [WIDTH-1:0] q
);

`ifdef LROT_DIR_EN
  always_comb begin
    q = {d[WIDTH-2:0], d[WIDTH-1]};
    if (dir) begin
      q = {d[0], d[WIDTH-1:1]};
    end
  end
`else
  assign q = {d[WIDTH-2:0], d[WIDTH-1]};
`endif

endmodule : lrot16_step

// File: rtl/lrotate16_seq.sv
// Sequential 16-bit rotate unit: accepts an operand and amount over a
// valid/ready handshake, rotates one position per clock, then holds the
// result until the consumer takes it.
// Optional feature macro: LROT_DIR_EN (adds dir input, latched at accept).
// Ports:
//   clk, rst  : clock, synchronous active-high reset
//   in_valid  : operation offered       in_ready : unit idle, can accept
//   A, shl    : operand, rotate amount  dir      : 1 = rotate right (optional)
//   out_valid : result held on OUT      out_ready: consumer takes result
//   OUT       : result (data register)  busy     : rotating or holding
module lrotate16_seq
  import lrot_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [SHW-1:0]   shl,
`ifdef LROT_DIR_EN
  input  logic             dir,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] OUT,
  output logic             busy
);

  state_t           state, state_nxt;
  logic [WIDTH-1:0] data_r, data_nxt;
  logic [SHW-1:0]   cnt_r, cnt_nxt;
  logic [WIDTH-1:0] step_q;

`ifdef LROT_DIR_EN
  logic dir_r, dir_nxt;
`endif

  // Single-position rotator feeding the data register.
  lrot16_step u_step (
    .d   (data_r),
`ifdef LROT_DIR_EN
    .dir (dir_r),
`endif
    .q   (step_q)
  );

  // State, data and counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_IDLE;
      data_r <= '0;
      cnt_r  <= '0;
`ifdef LROT_DIR_EN
      dir_r  <= 1'b0;
`endif
    end else begin
      state  <= state_nxt;
      data_r <= data_nxt;
      cnt_r  <= cnt_nxt;
`ifdef LROT_DIR_EN
      dir_r  <= dir_nxt;
`endif
    end
  end

  // Next-state and datapath control.
  always_comb begin
    state_nxt = state;
    data_nxt  = data_r;
    cnt_nxt   = cnt_r;
`ifdef LROT_DIR_EN
    dir_nxt   = dir_r;
`endif
    case (state)
      S_IDLE: begin
        if (in_valid) begin
          data_nxt  = A;
          cnt_nxt   = shl;
`ifdef LROT_DIR_EN
          dir_nxt   = dir;
`endif
          // A zero amount skips straight to presenting the operand.
          state_nxt = (shl == SHW'(0)) ? S_HOLD : S_ROT;
        end
      end
      S_ROT: begin
        data_nxt = step_q;
        cnt_nxt  = cnt_r - SHW'(1);
        // Exit on the last rotate so the counter never wraps.
        if (cnt_r == SHW'(1)) begin
          state_nxt = S_HOLD;
        end
      end
      S_HOLD: begin
        if (out_ready) begin
          state_nxt = S_IDLE;
        end
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // Outputs decoded from state; readiness is withheld while reset is asserted
  // because any offer made then would be discarded.
  assign in_ready  = (state == S_IDLE) && !rst;
  assign out_valid = (state == S_HOLD);
  assign busy      = (state != S_IDLE);
  assign OUT       = data_r;

endmodule : lrotate16_seq
